pos_nor: RTL and testbench

- Registered bitwise NOR unit for the ALU datapath: OUT = ~(A | B) per bit, realised in product-of-sums form (~A & ~B).
- One-cycle pipeline stage with a valid handshake and result flags (zero, all-ones, popcount) for the ALU status logic.
- Sits alongside the other logic-op units and feeds the ALU result mux.

---
 rtl/pos_nor.sv | 81 ++++++++
 tb/tb_pos_nor.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pos_nor.sv
// pos_nor: registered bitwise NOR unit (product-of-sums form, ~A & ~B) with
// result flags for the ALU status logic. One-cycle latency, no stalls.
//   clk, rst        : clock, synchronous active-high reset
//   A, B, in_valid  : operands and their qualifier
//   OUT, out_valid  : registered result and its one-cycle valid strobe
//   zero_flag       : OUT == 0
//   ones_flag       : OUT all ones
//   ones_count      : number of set bits in OUT
module pos_nor #(
  parameter int WIDTH = 16,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] OUT,
  output logic             out_valid,
  output logic             zero_flag,
  output logic             ones_flag,
  output logic [CW-1:0]    ones_count
);

  logic [WIDTH-1:0] nor_w;
  logic [CW-1:0]    cnt_w;

  logic [WIDTH-1:0] out_d,   out_q;
  logic             valid_d, valid_q;
  logic             zero_d,  zero_q;
  logic             ones_d,  ones_q;
  logic [CW-1:0]    count_d, count_q;

  always_comb begin
    nor_w = ~A & ~B;
    cnt_w = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_w = cnt_w + CW'(nor_w[i]);
    end
  end

  // Result and flags only load together when in_valid is high, so they can
  // never disagree and never track A/B while idle.
  always_comb begin
    out_d   = out_q;
    zero_d  = zero_q;
    ones_d  = ones_q;
    count_d = count_q;
    valid_d = 1'b0;
    if (in_valid) begin
      out_d   = nor_w;
      zero_d  = ~|nor_w;
      ones_d  = &nor_w;
      count_d = cnt_w;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b1;
      ones_q  <= 1'b0;
      count_q <= '0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      ones_q  <= ones_d;
      count_q <= count_d;
    end
  end

  assign OUT        = out_q;
  assign out_valid  = valid_q;
  assign zero_flag  = zero_q;
  assign ones_flag  = ones_q;
  assign ones_count = count_q;

endmodule

// File: tb/tb_pos_nor.sv
// Testbench for pos_nor (WIDTH=16): table vectors plus scoreboard queue.
module tb_pos_nor;

  typedef struct {
    logic [15:0] out;
    logic        zero;
    logic        ones;
    logic [4:0]  cnt;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A, B;
  logic        in_valid;
  logic [15:0] OUT;
  logic        out_valid;
  logic        zero_flag;
  logic        ones_flag;
  logic [4:0]  ones_count;

  int n_checks = 0;
  int n_fail   = 0;

  res_t sb[$];
  res_t held;

  pos_nor #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .in_valid(in_valid),
    .OUT(OUT), .out_valid(out_valid), .zero_flag(zero_flag),
    .ones_flag(ones_flag), .ones_count(ones_count)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t r;
    logic [15:0] o;
    o = 16'hFFFF ^ (a | b);
    r.out  = o;
    r.zero = (o == 16'h0000);
    r.ones = (o == 16'hFFFF);
    r.cnt  = '0;
    for (int i = 0; i < 16; i++) if (o[i]) r.cnt = r.cnt + 5'd1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, " OUT"},        32'(OUT),        32'(e.out));
    chk({tag, " zero_flag"},  32'(zero_flag),  32'(e.zero));
    chk({tag, " ones_flag"},  32'(ones_flag),  32'(e.ones));
    chk({tag, " ones_count"}, 32'(ones_count), 32'(e.cnt));
  endtask

  // Drive one cycle; expectation is queued when a real operation is issued.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [15:0] a, input logic [15:0] b, input res_t e);
    rst = r; in_valid = v; A = a; B = b;
    if (v && !r) sb.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      held = '{out: 16'h0000, zero: 1'b1, ones: 1'b0, cnt: 5'd0};
      chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
      chk_res(tag, held);
    end else if (v) begin
      chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s scoreboard: got empty queue expected entry", tag);
      end else begin
        held = sb.pop_front();
        chk_res(tag, held);
      end
    end else begin
      chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
      chk_res(tag, held);
    end
  endtask

  vec_t tbl[5];
  res_t dummy;

  initial begin
    dummy = '{out: 16'h0, zero: 1'b0, ones: 1'b0, cnt: 5'd0};
    tbl[0] = '{a: 16'h0000, b: 16'h68AF, exp: '{out: 16'h9750, zero: 1'b0, ones: 1'b0, cnt: 5'd7}};
    tbl[1] = '{a: 16'hFFFF, b: 16'hFF55, exp: '{out: 16'h0000, zero: 1'b1, ones: 1'b0, cnt: 5'd0}};
    tbl[2] = '{a: 16'h0000, b: 16'hCCCC, exp: '{out: 16'h3333, zero: 1'b0, ones: 1'b0, cnt: 5'd8}};
    tbl[3] = '{a: 16'h0000, b: 16'h0000, exp: '{out: 16'hFFFF, zero: 1'b0, ones: 1'b1, cnt: 5'd16}};
    tbl[4] = '{a: 16'h8001, b: 16'h0100, exp: '{out: 16'h7EFE, zero: 1'b0, ones: 1'b0, cnt: 5'd13}};

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0;
    held = dummy;

    // Reset with operands asserted: rst wins.
    for (int i = 0; i < 2; i++) step("reset", 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, dummy);

    // Table vectors, each separated by an idle cycle.
    for (int i = 0; i < 5; i++) begin
      step($sformatf("vec%0d", i), 1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].exp);
      step($sformatf("vec%0d_idle", i), 1'b0, 1'b0, 16'($urandom), 16'($urandom), dummy);
    end

    // Back-to-back then hold with garbage operands.
    for (int i = 0; i < 3; i++)
      step($sformatf("b2b%0d", i), 1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].exp);
    for (int i = 0; i < 3; i++)
      step($sformatf("hold%0d", i), 1'b0, 1'b0, 16'($urandom), 16'($urandom), dummy);

    // Random back-to-back stream checked against the model.
    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom); rb = 16'($urandom);
      if (i % 5 == 0) rb = 16'h0000;
      if (i % 7 == 0) ra = 16'h0000;
      step($sformatf("rnd%0d", i), 1'b0, 1'b1, ra, rb, model(ra, rb));
    end

    // Reset mid-stream discards the operation in that cycle.
    step("pre_rst", 1'b0, 1'b1, 16'h0000, 16'hCCCC, tbl[2].exp);
    step("rst_prio", 1'b1, 1'b1, 16'h0000, 16'h0000, dummy);
    step("post_rst_idle", 1'b0, 1'b0, 16'h1234, 16'h0000, dummy);
    step("post_rst", 1'b0, 1'b1, 16'h0000, 16'h0000, tbl[3].exp);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
